// File: rtl/timer_seq_if.sv
// timer_seq control/status bundle.
// master drives requests, slave reports progress.
interface timer_seq_if #(
  parameter int CNT_W  = 4,
  parameter int PASS_W = 2
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  limit;
  logic [PASS_W-1:0] passes;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [CNT_W-1:0]  cnt;
  logic [PASS_W-1:0] pass_idx;

  modport master (
    output start, abort, limit, passes,
    input  busy, done, aborted, cnt, pass_idx
  );

  modport slave (
    input  start, abort, limit, passes,
    output busy, done, aborted, cnt, pass_idx
  );
endinterface

// File: rtl/timer_seq.sv
// Multi-pass sequencer: a master FSM arms a counter FSM
// once per pass and reports done/aborted pulses.
module timer_seq #(
  parameter int CNT_W  = 4,
  parameter int PASS_W = 2
) (
  input logic        clk,
  input logic        rst,
  timer_seq_if.slave tmr
);
  typedef enum logic [1:0] {
    M_IDLE, M_ARM, M_RUN, M_LAST
  } mst_e;

  typedef enum logic {
    C_S0, C_S1
  } cst_e;

  mst_e              mst_q, mst_d;
  cst_e              cst_q, cst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              done_q, done_d;
  logic              abrt_q, abrt_d;

  logic enter;
  logic exit_s;
  logic abort_acc;

  assign enter     = (mst_q == M_ARM);
  assign exit_s    = (cst_q == C_S1) && (cnt_q == limit_q);
  assign abort_acc = tmr.abort && (mst_q != M_IDLE);

  // Master FSM: pass sequencing, latching and result pulses.
  always_comb begin
    mst_d    = mst_q;
    pass_d   = pass_q;
    limit_d  = limit_q;
    passes_d = passes_q;
    done_d   = 1'b0;
    abrt_d   = 1'b0;
    if (abort_acc) begin
      mst_d  = M_IDLE;
      pass_d = '0;
      abrt_d = 1'b1;
    end else begin
      unique case (mst_q)
        M_IDLE: begin
          if (tmr.start) begin
            mst_d    = M_ARM;
            limit_d  = tmr.limit;
            passes_d = tmr.passes;
            pass_d   = '0;
          end
        end
        M_ARM: mst_d = M_RUN;
        M_RUN: begin
          if (exit_s) begin
            if (pass_q == passes_q) begin
              mst_d  = M_LAST;
              done_d = 1'b1;
            end else begin
              mst_d  = M_ARM;
              pass_d = pass_q + 1'b1;
            end
          end
        end
        M_LAST: mst_d = M_IDLE;
        default: mst_d = M_IDLE;
      endcase
    end
  end

  // Counter FSM: counts 0..limit once per enter strobe.
  always_comb begin
    cst_d = cst_q;
    cnt_d = cnt_q;
    if (abort_acc) begin
      cst_d = C_S0;
      cnt_d = '0;
    end else begin
      unique case (cst_q)
        C_S0: begin
          if (enter) begin
            cst_d = C_S1;
            cnt_d = '0;
          end
        end
        C_S1: begin
          if (exit_s) begin
            cst_d = C_S0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cst_d = C_S0;
          cnt_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_q    <= M_IDLE;
      cst_q    <= C_S0;
      cnt_q    <= '0;
      limit_q  <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      done_q   <= 1'b0;
      abrt_q   <= 1'b0;
    end else begin
      mst_q    <= mst_d;
      cst_q    <= cst_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      done_q   <= done_d;
      abrt_q   <= abrt_d;
    end
  end

  assign tmr.busy     = (mst_q != M_IDLE);
  assign tmr.done     = done_q;
  assign tmr.aborted  = abrt_q;
  assign tmr.cnt      = cnt_q;
  assign tmr.pass_idx = pass_q;
endmodule

// File: tb/tb_timer_seq.sv
// Directed bench for timer_seq: narrow and wide
// instances, cycle-exact expected vectors.
module tb_timer_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_seq_if #(.CNT_W(4), .PASS_W(2)) b4 ();
  timer_seq_if #(.CNT_W(8), .PASS_W(4)) b8 ();

  timer_seq #(.CNT_W(4), .PASS_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .tmr (b4.slave)
  );

  timer_seq #(.CNT_W(8), .PASS_W(4)) u_wide (
    .clk (clk),
    .rst (rst),
    .tmr (b8.slave)
  );

  int nvec = 0;
  int nerr = 0;
  logic [8:0] got, exp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] obs();
    return {b4.busy, b4.done, b4.aborted, b4.cnt, b4.pass_idx};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    b4.start = 1'b0; b4.abort = 1'b0;
    b4.limit = '0;   b4.passes = '0;
    b8.start = 1'b0; b8.abort = 1'b0;
    b8.limit = '0;   b8.passes = '0;
    tick; tick;
    got = obs(); exp = 9'h000;
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL reset_state got %h want %h", got, exp);
    end
    rst = 1'b0;
    tick;
    b4.abort = 1'b1;
    tick;
    b4.abort = 1'b0;
    got = obs(); exp = 9'h000;
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL idle_abort got %h want %h", got, exp);
    end
    tick;
  endtask

  task automatic test_single;
    b4.limit = 4'd9; b4.passes = 2'd0; b4.start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick;
      if (c == 1) b4.start = 1'b0;
      exp = {(c <= 12), (c == 12), 1'b0,
             4'((c >= 2 && c <= 11) ? c - 2 : 0), 2'd0};
      got = obs();
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL single c=%0d got %h want %h", c, got, exp);
      end
    end
  endtask

  task automatic test_multi;
    int k, p;
    b4.limit = 4'd3; b4.passes = 2'd2; b4.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick;
      if (c == 1) b4.start = 1'b0;
      k = (c - 1) % 5;
      p = (c - 1) / 5;
      if (c == 16) exp = {1'b1, 1'b1, 1'b0, 4'd0, 2'd2};
      else exp = {1'b1, 1'b0, 1'b0, 4'(k == 0 ? 0 : k - 1), 2'(p)};
      got = obs();
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL multi c=%0d got %h want %h", c, got, exp);
      end
    end
    tick;
    nvec++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin
      nerr++;
      $display("FAIL multi_end busy=%b done=%b want 0 0",
               b4.busy, b4.done);
    end
  endtask

  task automatic test_zero;
    logic [8:0] tbl [1:4];
    tbl[1] = {1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[2] = {1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[3] = {1'b1, 1'b1, 1'b0, 4'd0, 2'd0};
    tbl[4] = 9'h000;
    b4.limit = 4'd0; b4.passes = 2'd0; b4.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 1) b4.start = 1'b0;
      got = obs();
      nvec++;
      if (got !== tbl[c]) begin
        nerr++;
        $display("FAIL zero c=%0d got %h want %h", c, got, tbl[c]);
      end
    end
  endtask

  task automatic test_abort;
    b4.limit = 4'd9; b4.passes = 2'd0; b4.start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick;
      b4.start = 1'b0;
      b4.abort = 1'b0;
      if (c <= 6) exp = {1'b1, 1'b0, 1'b0, 4'(c >= 2 ? c - 2 : 0), 2'd0};
      else if (c == 7) exp = {1'b0, 1'b0, 1'b1, 4'd0, 2'd0};
      else if (c == 8) exp = {1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
      else if (c <= 11) exp = {1'b1, 1'b0, 1'b0, 4'(c - 9), 2'd0};
      else if (c == 12) exp = {1'b1, 1'b1, 1'b0, 4'd0, 2'd0};
      else exp = 9'h000;
      got = obs();
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL abort c=%0d got %h want %h", c, got, exp);
      end
      if (c == 6) b4.abort = 1'b1;
      if (c == 7) begin
        b4.start = 1'b1;
        b4.limit = 4'd2;
      end
    end
  endtask

  task automatic test_abort_exit;
    b4.limit = 4'd2; b4.passes = 2'd1; b4.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      b4.start = 1'b0;
      b4.abort = 1'b0;
      if (c == 1) exp = {1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
      else if (c <= 4) exp = {1'b1, 1'b0, 1'b0, 4'(c - 2), 2'd0};
      else if (c == 5) exp = {1'b0, 1'b0, 1'b1, 4'd0, 2'd0};
      else exp = 9'h000;
      got = obs();
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL abort_exit c=%0d got %h want %h", c, got, exp);
      end
      if (c == 4) b4.abort = 1'b1;
    end
  endtask

  task automatic test_abort_last;
    b4.limit = 4'd0; b4.passes = 2'd0; b4.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      b4.start = 1'b0;
      b4.abort = 1'b0;
      if (c <= 2) exp = {1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
      else if (c == 3) exp = {1'b1, 1'b1, 1'b0, 4'd0, 2'd0};
      else if (c == 4) exp = {1'b0, 1'b0, 1'b1, 4'd0, 2'd0};
      else exp = 9'h000;
      got = obs();
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL abort_last c=%0d got %h want %h", c, got, exp);
      end
      if (c == 3) b4.abort = 1'b1;
    end
  endtask

  task automatic test_back_to_back;
    int r, k, p;
    b4.limit = 4'd1; b4.passes = 2'd0; b4.start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      tick;
      if (c == 1) begin
        b4.limit = 4'd5;
        b4.passes = 2'd3;
      end
      if (c == 6) b4.start = 1'b0;
      r = c - 5;
      k = (r - 1) % 7;
      p = (r - 1) / 7;
      if (c <= 2) exp = {1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
      else if (c == 3) exp = {1'b1, 1'b0, 1'b0, 4'd1, 2'd0};
      else if (c == 4) exp = {1'b1, 1'b1, 1'b0, 4'd0, 2'd0};
      else if (c == 5) exp = 9'h000;
      else if (c < 34) exp = {1'b1, 1'b0, 1'b0, 4'(k == 0 ? 0 : k - 1), 2'(p)};
      else if (c == 34) exp = {1'b1, 1'b1, 1'b0, 4'd0, 2'd3};
      else exp = {1'b0, 1'b0, 1'b0, 4'd0, 2'd3};
      got = obs();
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL back_to_back c=%0d got %h want %h", c, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    b4.limit = 4'd9; b4.passes = 2'd1; b4.start = 1'b1;
    tick;
    b4.start = 1'b1;
    tick; tick; tick;
    #2 rst = 1'b1;
    #1;
    got = obs(); exp = 9'h000;
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL reset_async got %h want %h", got, exp);
    end
    tick;
    got = obs();
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL reset_hold got %h want %h", got, exp);
    end
    #2 rst = 1'b0;
    b4.limit = 4'd0; b4.passes = 2'd0; b4.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      b4.start = 1'b0;
      if (c <= 2) exp = {1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
      else if (c == 3) exp = {1'b1, 1'b1, 1'b0, 4'd0, 2'd0};
      else exp = 9'h000;
      got = obs();
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL reset_restart c=%0d got %h want %h", c, got, exp);
      end
    end
  endtask

  task automatic test_wide;
    int ndone;
    int dcyc;
    ndone = 0;
    dcyc = -1;
    b8.limit = 8'd255; b8.passes = 4'd15; b8.start = 1'b1;
    for (int c = 1; c <= 4114; c++) begin
      tick;
      b8.start = 1'b0;
      if (b8.done === 1'b1) begin
        ndone++;
        dcyc = c;
      end
      if (c == 257) begin
        nvec++;
        if (b8.cnt !== 8'd255 || b8.pass_idx !== 4'd0) begin
          nerr++;
          $display("FAIL wide_top cnt=%0d pass=%0d want 255 0",
                   b8.cnt, b8.pass_idx);
        end
      end
      if (c == 258) begin
        nvec++;
        if (b8.cnt !== 8'd0 || b8.pass_idx !== 4'd1) begin
          nerr++;
          $display("FAIL wide_arm cnt=%0d pass=%0d want 0 1",
                   b8.cnt, b8.pass_idx);
        end
      end
      if (c == 4113) begin
        nvec++;
        if (b8.done !== 1'b1 || b8.pass_idx !== 4'd15) begin
          nerr++;
          $display("FAIL wide_done done=%b pass=%0d want 1 15",
                   b8.done, b8.pass_idx);
        end
      end
      if (c == 4114) begin
        nvec++;
        if (b8.busy !== 1'b0) begin
          nerr++;
          $display("FAIL wide_idle busy=%b want 0", b8.busy);
        end
      end
    end
    nvec++;
    if (ndone != 1 || dcyc != 4113) begin
      nerr++;
      $display("FAIL wide_pulse count=%0d at=%0d want 1 at 4113",
               ndone, dcyc);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_zero;
    test_abort;
    test_abort_exit;
    test_abort_last;
    test_back_to_back;
    test_reset_mid;
    test_wide;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
